// File: rtl/codifica_hamming_serial_pkg.sv
// Shared constants and FSM state type for the serial Hamming(15,11) encoder.
package codigo_hamming_pkg;

  localparam int K = 11;
  localparam int N = 15;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P3 = 3;
  localparam int P7 = 7;

  typedef enum logic {
    OCIOSO    = 1'b0,
    TRANSMITE = 1'b1
  } estado_t;

endpackage

// File: rtl/codifica_hamming_serial_gera_paridade.sv
// Combinational Hamming(15,11) encoder: spreads data over non-power-of-two
// positions and fills positions 1, 2, 4, 8 (indices 0, 1, 3, 7) with even parity.
module gera_paridade_hamming
  import codigo_hamming_pkg::*;
(
  input  logic [K-1:0] dado_i,
  output logic [N-1:0] palavra_o
);

  logic [N-1:0] c;

  always_comb begin
    c          = '0;
    c[2]       = dado_i[0];
    c[6:4]     = dado_i[3:1];
    c[11:8]    = dado_i[7:4];
    c[14:12]   = dado_i[10:8];
    // each parity bit covers the positions whose 1-based index has that bit set
    c[P0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[P1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[P3] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[P7] = ^c[14:8];
  end

  assign palavra_o = c;

endmodule

// File: rtl/codifica_hamming_serial.sv
// Serial Hamming(15,11) encoder: accepts an 11-bit word, sends its codeword LSB first.
// Optional CODIFICA_HAMMING_PARIDADE_GLOBAL_EN appends an overall parity bit (SECDED).
module codifica_hamming_serial
  import codigo_hamming_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K-1:0]  dado_in,
  input  logic          dado_valid,
  output logic          dado_ready,
  output logic          tx_bit,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_inicio,
  output logic          tx_fim,
  output logic [N-1:0]  palavra_out
);

`ifdef CODIFICA_HAMMING_PARIDADE_GLOBAL_EN
  localparam int FW = N + 1;
`else
  localparam int FW = N;
`endif
  localparam logic [3:0] ULTIMO = 4'(FW - 1);

  logic [N-1:0]  palavra_d;
  logic [FW-1:0] quadro_d;
  logic [FW-1:0] quadro_q;
  estado_t       estado_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          tx_bit_q;
  logic          tx_valid_q;
  logic          tx_inicio_q;
  logic          tx_fim_q;
  logic          aceita;
  logic          avanca;

  gera_paridade_hamming u_gera_paridade (
    .dado_i    (dado_in),
    .palavra_o (palavra_d)
  );

`ifdef CODIFICA_HAMMING_PARIDADE_GLOBAL_EN
  assign quadro_d = {^palavra_d, palavra_d};
`else
  assign quadro_d = palavra_d;
`endif

  // tx_fim_q is only ever set in TRANSMITE, so it alone marks the last-bit slot
  assign dado_ready = rst_n && ((estado_q == OCIOSO) || (tx_fim_q && tx_ready));
  assign aceita     = dado_valid && dado_ready;
  assign avanca     = tx_valid_q && tx_ready;
  assign cnt_d      = cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      quadro_q    <= '0;
      cnt_q       <= '0;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_inicio_q <= 1'b0;
      tx_fim_q    <= 1'b0;
    end else if (aceita) begin
      estado_q    <= TRANSMITE;
      quadro_q    <= quadro_d;
      cnt_q       <= '0;
      tx_bit_q    <= quadro_d[0];
      tx_valid_q  <= 1'b1;
      tx_inicio_q <= 1'b1;
      tx_fim_q    <= 1'b0;
    end else if (avanca) begin
      if (tx_fim_q) begin
        estado_q    <= OCIOSO;
        cnt_q       <= '0;
        tx_bit_q    <= 1'b0;
        tx_valid_q  <= 1'b0;
        tx_inicio_q <= 1'b0;
        tx_fim_q    <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        tx_bit_q    <= quadro_q[cnt_d];
        tx_inicio_q <= 1'b0;
        tx_fim_q    <= (cnt_d == ULTIMO);
      end
    end
  end

  assign tx_bit      = tx_bit_q;
  assign tx_valid    = tx_valid_q;
  assign tx_inicio   = tx_inicio_q;
  assign tx_fim      = tx_fim_q;
  assign palavra_out = quadro_q[N-1:0];

endmodule

// File: tb/tb_codifica_hamming_serial.sv
// Directed bench for codifica_hamming_serial; frame length follows
// CODIFICA_HAMMING_PARIDADE_GLOBAL_EN when defined.
module tb_codifica_hamming_serial;

`ifdef CODIFICA_HAMMING_PARIDADE_GLOBAL_EN
  localparam int LEN = 16;
  localparam logic [15:0] F001 = 16'h8007;
  localparam logic [15:0] F7FF = 16'hFFFF;
`else
  localparam int LEN = 15;
  localparam logic [15:0] F001 = 16'h0007;
  localparam logic [15:0] F7FF = 16'h7FFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] dado_in;
  logic        dado_valid;
  logic        dado_ready;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_inicio;
  logic        tx_fim;
  logic [14:0] palavra_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codifica_hamming_serial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dado_in     (dado_in),
    .dado_valid  (dado_valid),
    .dado_ready  (dado_ready),
    .tx_bit      (tx_bit),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_inicio   (tx_inicio),
    .tx_fim      (tx_fim),
    .palavra_out (palavra_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receives one frame starting right after acceptance; toggle drives tx_ready 1,0,0,1,0,0...
  task automatic recv_frame(input string tag, input logic [15:0] expf, input bit toggle);
    int i = 0;
    int c = 0;
    while (i < LEN && c < 100) begin
      tx_ready = toggle ? ((c % 3) == 0) : 1'b1;
      #1;
      chk({tag, "_valid"}, 16'(tx_valid), 16'd1);
      chk({tag, "_bit"}, 16'(tx_bit), 16'(expf[i]));
      chk({tag, "_ini"}, 16'(tx_inicio), 16'(i == 0));
      chk({tag, "_fim"}, 16'(tx_fim), 16'(i == LEN - 1));
      chk({tag, "_rdy"}, 16'(dado_ready), 16'((i == LEN - 1) && tx_ready));
      if (tx_ready) i++;
      c++;
      step();
    end
    chk({tag, "_timeout"}, 16'(i), 16'(LEN));
    tx_ready = 1'b1;
    #1;
    chk({tag, "_idle"}, 16'(tx_valid), 16'd0);
  endtask

  function automatic logic [10:0] corrige(input logic [14:0] cw);
    logic [3:0]  s = '0;
    logic [14:0] c = cw;
    for (int j = 0; j < 15; j++)
      if (cw[j]) s = s ^ 4'(j + 1);
    if (s != 0) c[s - 1] = ~c[s - 1];
    return {c[14:12], c[11:8], c[6:4], c[2]};
  endfunction

  function automatic logic [3:0] sindrome(input logic [14:0] cw);
    logic [3:0] s = '0;
    for (int j = 0; j < 15; j++)
      if (cw[j]) s = s ^ 4'(j + 1);
    return s;
  endfunction

  initial begin
    int nvalid, nfim, cyc, fim1, ini2, nini;
    logic [10:0] w;
    logic [14:0] cw;

    rst_n = 1'b0; dado_in = '0; dado_valid = 1'b0; tx_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 16'(tx_valid), 16'd0);
    chk("rst_palavra", 16'(palavra_out), 16'd0);
    chk("rst_bit", 16'(tx_bit), 16'd0);
    chk("rst_ini", 16'(tx_inicio), 16'd0);
    chk("rst_fim", 16'(tx_fim), 16'd0);
    chk("rst_rdy", 16'(dado_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 16'(dado_ready), 16'd1);

    // single word 0x001, continuous tx_ready
    dado_in = 11'h001; dado_valid = 1'b1;
    step();
    dado_valid = 1'b0;
    chk("w001_palavra", 16'(palavra_out), 16'h0007);
    recv_frame("w001", F001, 1'b0);

    dado_in = 11'h7FF; dado_valid = 1'b1;
    step();
    dado_valid = 1'b0;
    chk("w7ff_palavra", 16'(palavra_out), 16'h7FFF);
    recv_frame("w7ff", F7FF, 1'b0);

    // back-to-back: 0x000 then 0x7FF held on the input
    dado_in = 11'h000; dado_valid = 1'b1;
    step();
    chk("b2b_palavra0", 16'(palavra_out), 16'h0000);
    dado_in = 11'h7FF;
    nvalid = 0; nfim = 0; nini = 0; fim1 = -1; ini2 = -1;
    for (cyc = 0; cyc < 3 * LEN; cyc++) begin
      #1;
      if (tx_valid) nvalid++;
      if (tx_inicio) begin
        nini++;
        if (nini == 2) begin
          ini2 = cyc;
          chk("b2b_palavra1", 16'(palavra_out), 16'h7FFF);
        end
      end
      if (tx_fim) begin
        nfim++;
        if (nfim == 1) begin
          fim1 = cyc;
          chk("b2b_rdy_fim", 16'(dado_ready), 16'd1);
        end
        if (nfim == 2) dado_valid = 1'b0;
      end
      step();
    end
    chk("b2b_nvalid", 16'(nvalid), 16'(2 * LEN));
    chk("b2b_gap", 16'(ini2), 16'(fim1 + 1));

    // stalled transmission must carry the same content
    dado_in = 11'h001; dado_valid = 1'b1;
    step();
    dado_valid = 1'b0;
    recv_frame("stall001", F001, 1'b1);

    // reset in the middle of a frame
    dado_in = 11'h7FF; dado_valid = 1'b1;
    step();
    dado_valid = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("mid_valid", 16'(tx_valid), 16'd1);
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 16'(tx_valid), 16'd0);
    chk("mrst_palavra", 16'(palavra_out), 16'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_rdy", 16'(dado_ready), 16'd1);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid) nvalid++;
      step();
    end
    chk("mrst_residual", 16'(nvalid), 16'd0);

    // loopback through a single-error corrector
    for (int n = 0; n < 15; n++) begin
      w = 11'($urandom_range(0, 2047));
      dado_in = w; dado_valid = 1'b1;
      step();
      dado_valid = 1'b0;
      cw = palavra_out;
      chk("lb_sindrome", 16'(sindrome(cw)), 16'd0);
      cw[n] = ~cw[n];
      chk("lb_dado", 16'(corrige(cw)), 16'(w));
      for (int k = 0; k < LEN; k++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codifica_hamming_serial.md
CODIFICA_HAMMING_SERIAL -- requirements
Module: codifica_hamming_serial

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (K=11 data bits, N=15 codeword bits).
REQ-002 The port list SHALL be:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- dado_in  input  11  data word to encode.
- dado_valid  input  1  dado_in is valid.
- dado_ready  output  1  block accepts dado_in this cycle.
- tx_bit  output  1  current serial codeword bit.
- tx_valid  output  1  tx_bit is valid.
- tx_ready  input  1  downstream consumes tx_bit this cycle.
- tx_inicio  output  1  tx_bit is the first bit of a frame.
- tx_fim  output  1  tx_bit is the last bit of a frame.
- palavra_out  output  15  parallel copy of the frame's codeword, held for the whole frame.

Function
REQ-003 The codeword SHALL map data as c[2]=d[0], c[6:4]=d[3:1], c[11:8]=d[7:4], c[14:12]=d[10:8].
REQ-004 Parity bits SHALL be even parity:
- c[0] = XOR of c[2,4,6,8,10,12,14]
- c[1] = XOR of c[2,5,6,9,10,13,14]
- c[3] = XOR of c[4,5,6,11,12,13,14]
- c[7] = XOR of c[8..14]
REQ-005 The FSM SHALL have two states: OCIOSO and TRANSMITE.
REQ-006 A transfer is accepted on a cycle with dado_valid=1 and dado_ready=1; the encoded codeword is registered on that edge.
REQ-007 dado_ready SHALL be 1 when:
- the state is OCIOSO, or
- the state is TRANSMITE with tx_fim=1 and tx_ready=1 (back-to-back frames).
It SHALL be 0 otherwise.
REQ-008 tx_valid SHALL be 1 exactly when the state is TRANSMITE, starting the cycle after acceptance (latency 1).
REQ-009 Bits SHALL be sent in index order c[0] first, c[14] last, using a 4-bit counter (0..14).
REQ-010 The counter SHALL advance only on cycles with tx_valid=1 and tx_ready=1; tx_bit SHALL be held stable while tx_ready=0.
REQ-011 tx_inicio SHALL be 1 when the counter is 0; tx_fim SHALL be 1 when the counter is at the last index.
REQ-012 On a handshake of the last bit:
- with a new word accepted the same cycle, the FSM SHALL stay in TRANSMITE with the counter at 0 and the new codeword loaded (no idle gap);
- otherwise it SHALL return to OCIOSO.
REQ-013 dado_valid while dado_ready=0 SHALL be ignored; dado_in is not sampled.

Reset
REQ-014 With rst_n=0 at a clock edge, the block SHALL go to OCIOSO with:
- counter = 0
- palavra_out = 0
- tx_bit, tx_valid, tx_inicio, tx_fim = 0
- dado_ready = 0 during the reset cycle, then 1 after release.
REQ-015 Reset mid-frame SHALL abort the frame; no remaining bits are sent after release.

Configuration
REQ-016 With macro CODIFICA_HAMMING_PARIDADE_GLOBAL_EN defined:
- a 16th bit (XOR of c[14:0], even overall parity, SECDED) SHALL be appended as the last serial bit;
- the frame length is 16 and tx_fim is asserted on index 15;
- palavra_out stays 15 bits.
REQ-017 Without the macro, the frame length SHALL be 15 and no extra logic is present.

Structure
REQ-018 A package codigo_hamming_pkg SHALL hold:
- constants K=11, N=15;
- parity index constants 0, 1, 3, 7;
- the FSM state typedef.
REQ-019 The combinational encoder (REQ-003/004) SHALL be a sub-module gera_paridade_hamming (11 in, 15 out), instantiated once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- dado_in=11'h001 accepted, tx_ready=1 -> palavra_out=15'h0007; serial bits 1,1,1 then twelve 0s; tx_inicio on bit 0, tx_fim on bit 14. With the macro: bit 15=1.
- dado_in=11'h7FF -> palavra_out=15'h7FFF; all 15 serial bits 1. With the macro: bit 15=1.
- dado_in=11'h000 then 11'h7FF presented continuously -> second tx_inicio is the cycle right after the first tx_fim; exactly 30 tx_valid cycles.
- tx_ready toggled 1,0,0,1... -> tx_bit and the counter are held during low cycles; frame content is identical to the tx_ready=1 case; dado_ready stays 0 mid-frame.
- rst_n=0 at bit 7 of a frame -> next cycle tx_valid=0 and palavra_out=0; after release, dado_ready=1 and no residual bits are sent.
- Loopback of random words, with any single bit of palavra_out inverted, through the team's Hamming corrector -> recovered data equals dado_in for all 15 flip positions.
